// File: rtl/solver_pkg.sv
// Shared defaults and arbiter state type for the image memory arbiter.
package solver_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ADDR_W  = 19;
  localparam int unsigned DEF_DATA_W  = 10;
  localparam int unsigned DEF_RD_LAT  = 2;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_start,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = IW'((32'(i_start) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_mem_arbiter.sv
// Round-robin arbiter sharing one image memory port between solver requesters,
// with burst locking and in-order read response routing.
module image_mem_arbiter
  import solver_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RD_LAT  = DEF_RD_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_val,
  input  logic [NUM_REQ-1:0]           req_burst,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           rsp_val,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]   which_mem,
  output logic [7:0]                   debug_count
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_t                  r_state;
  logic [IW-1:0]               r_owner;
  logic [IW-1:0]               r_last;
  logic [NUM_REQ-1:0]          r_ack;
  logic [NUM_REQ-1:0]          r_rsp_val;
  logic [DATA_W-1:0]           r_rsp_data;
  logic [ADDR_W-1:0]           r_addr;
  logic                        r_we;
  logic [DATA_W-1:0]           r_wdata;
  logic [IW-1:0]               r_which;
  logic [7:0]                  r_count;
  logic [RD_LAT:0]             r_tag_v;
  logic [RD_LAT:0][IW-1:0]     r_tag_idx;

  logic [ADDR_W-1:0]           w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]           w_wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]          w_owner_mask;
  logic [NUM_REQ-1:0]          w_elig;
  logic [NUM_REQ-1:0]          w_grant;
  logic [IW-1:0]               w_idx;
  logic [IW-1:0]               w_start;
  logic                        w_any;
  logic                        w_rd_issue;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // A requester acked this cycle is not eligible, so a held request re-issues every other cycle.
  always_comb begin
    w_owner_mask          = '0;
    w_owner_mask[r_owner] = 1'b1;
    w_elig                = req_val & ~r_ack;
    if (r_state == LOCKED) begin
      w_elig = w_elig & w_owner_mask;
    end
  end

  assign w_start    = (r_last == IW'(NUM_REQ - 1)) ? '0 : r_last + IW'(1);
  assign w_rd_issue = w_any & ~req_we[w_idx];

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .i_req   (w_elig),
    .i_start (w_start),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= IW'(NUM_REQ - 1);
      r_ack      <= '0;
      r_rsp_val  <= '0;
      r_rsp_data <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_which    <= '0;
      r_count    <= '0;
      r_tag_v    <= '0;
      r_tag_idx  <= '0;
    end else begin
      r_ack <= w_grant;
      if (r_ack != '0) begin
        r_count <= r_count + 8'd1;
      end

      // Stage 0 holds the tag of the access currently on the memory port.
      r_tag_v   <= {r_tag_v[RD_LAT-1:0], w_rd_issue};
      r_tag_idx <= {r_tag_idx[RD_LAT-1:0], w_idx};

      r_rsp_val <= '0;
      if (r_tag_v[RD_LAT]) begin
        r_rsp_val[r_tag_idx[RD_LAT]] <= 1'b1;
        r_rsp_data                   <= mem_rdata;
      end

      if (w_any) begin
        r_we    <= req_we[w_idx];
        r_addr  <= w_addr_arr[w_idx];
        r_wdata <= w_wdata_arr[w_idx];
        r_which <= w_idx;
        r_last  <= w_idx;
        if (req_burst[w_idx]) begin
          r_state <= LOCKED;
          r_owner <= w_idx;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        r_we <= 1'b0;
        if (r_state == LOCKED && !req_val[r_owner] && !r_ack[r_owner]) begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign req_ack     = r_ack;
  assign rsp_val     = r_rsp_val;
  assign rsp_data    = r_rsp_data;
  assign mem_addr    = r_addr;
  assign mem_we      = r_we;
  assign mem_wdata   = r_wdata;
  assign which_mem   = r_which;
  assign debug_count = r_count;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Randomized bench for image_mem_arbiter against a transaction-level reference model.
module tb_image_mem_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 10;
  localparam int RD_LAT  = 2;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_val, req_burst, req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ack, rsp_val;
  logic [DATA_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic [1:0]                which_mem;
  logic [7:0]                debug_count;

  image_mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_burst   (req_burst),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ack     (req_ack),
    .rsp_val     (rsp_val),
    .rsp_data    (rsp_data),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .which_mem   (which_mem),
    .debug_count (debug_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the low address bits, RD_LAT cycles after the address is presented.
  logic [DATA_W-1:0] mpipe0 = '0;
  logic [DATA_W-1:0] mpipe1 = '0;
  always @(posedge clk) begin
    mpipe0 <= mem_addr[DATA_W-1:0];
    mpipe1 <= mpipe0;
  end
  assign mem_rdata = mpipe1;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state (values expected in the current cycle)
  logic [3:0]        m_ack;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [1:0]        m_which;
  logic [7:0]        m_count;
  logic [3:0]        m_rsp_val;
  logic [DATA_W-1:0] m_rsp_data;
  int                m_last;
  bit                m_locked;
  int                m_owner;
  bit                sched_v [16];
  logic [1:0]        sched_i [16];
  logic [DATA_W-1:0] sched_d [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [3:0]        n_ack;
    logic              n_we;
    logic [ADDR_W-1:0] n_addr;
    logic [DATA_W-1:0] n_wdata;
    logic [1:0]        n_which;
    logic [3:0]        elig;
    int                pick;
    int                slot;
    n_ack = '0; n_we = 1'b0; n_addr = m_addr; n_wdata = m_wdata; n_which = m_which;
    pick = -1;
    if (!reset) begin
      n_addr = '0; n_wdata = '0; n_which = '0;
      m_last = NUM_REQ - 1; m_locked = 0; m_owner = 0; m_count = '0; m_rsp_data = '0;
      for (int s = 0; s < 16; s++) sched_v[s] = 0;
    end else begin
      elig = req_val & ~m_ack;
      if (m_locked) elig = elig & (4'b0001 << m_owner);
      for (int k = 1; k <= NUM_REQ; k++)
        if (pick < 0 && elig[(m_last + k) % NUM_REQ]) pick = (m_last + k) % NUM_REQ;
      if (pick >= 0) begin
        n_ack[pick] = 1'b1;
        n_we    = req_we[pick];
        n_addr  = req_addr[pick*ADDR_W +: ADDR_W];
        n_wdata = req_wdata[pick*DATA_W +: DATA_W];
        n_which = 2'(pick);
        m_last   = pick;
        m_locked = req_burst[pick];
        m_owner  = pick;
        if (!req_we[pick]) begin
          slot = (cyc + 1 + RD_LAT + 1) % 16;
          sched_v[slot] = 1;
          sched_i[slot] = 2'(pick);
          sched_d[slot] = n_addr[DATA_W-1:0];
        end
      end else if (m_locked && !req_val[m_owner] && !m_ack[m_owner]) begin
        m_locked = 0;
      end
      if (m_ack != 0) m_count = m_count + 8'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
    m_ack = n_ack; m_we = n_we; m_addr = n_addr; m_wdata = n_wdata; m_which = n_which;
    slot = cyc % 16;
    m_rsp_val = '0;
    if (sched_v[slot]) begin
      m_rsp_val[sched_i[slot]] = 1'b1;
      m_rsp_data = sched_d[slot];
      sched_v[slot] = 0;
    end
    chk("req_ack", req_ack, m_ack);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("which_mem", which_mem, m_which);
    chk("debug_count", debug_count, m_count);
    chk("rsp_val", rsp_val, m_rsp_val);
    if (m_rsp_val != 0) chk("rsp_data", rsp_data, m_rsp_data);
    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic set_req(input int i, input bit b, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_val[i]   = 1'b1;
    req_burst[i] = b;
    req_we[i]    = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    req_val = '0; req_burst = '0; req_we = '0;
  endtask

  task automatic drain();
    clear_reqs();
    for (int k = 0; k < 6; k++) step();
  endtask

  task automatic rand_agents();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_val[i] && m_ack[i]) begin
        if ($urandom_range(1, 0) == 1)
          set_req(i, $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, ADDR_W'($urandom), DATA_W'($urandom));
        else
          req_val[i] = 1'b0;
      end else if (req_val[i]) begin
        if ($urandom_range(15, 0) == 0) req_val[i] = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        set_req(i, $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, ADDR_W'($urandom), DATA_W'($urandom));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp31 [5];
    logic [3:0] exp33 [7];
    int n, n1, nacks;
    exp31 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp33 = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b1000, 4'b0001, 4'b0000};
    m_ack = '0; m_we = 0; m_addr = '0; m_wdata = '0; m_which = '0; m_count = '0;
    m_rsp_val = '0; m_rsp_data = '0; m_last = NUM_REQ - 1; m_locked = 0; m_owner = 0;
    for (int s = 0; s < 16; s++) sched_v[s] = 0;
    reset = 1'b0;
    req_addr = '0; req_wdata = '0;
    clear_reqs();

    // Reset state
    step(); step();
    chk("rst_count", debug_count, 8'd0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // All four reading from reset: round-robin 0,1,2,3,0, first issue on first released edge
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 0, ADDR_W'(i * 16 + 1), '0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_order", req_ack, exp31[k]);
      for (int i = 0; i < NUM_REQ; i++)
        if (m_ack[i]) set_req(i, 0, 0, ADDR_W'(k * 64 + i), '0);
    end
    chk("rr_count4", debug_count, 8'd4);
    drain();

    // Single read from requester 2: latency and returned data
    set_req(2, 0, 0, 19'h12345, '0);
    n = 0;
    step();
    while (!req_ack[2] && n < 10) begin step(); n++; end
    chk("rd2_ack", req_ack[2], 1);
    req_val[2] = 1'b0;
    n = 0;
    while (!rsp_val[2] && n < 10) begin step(); n++; end
    chk("rd2_latency", n, RD_LAT + 1);
    chk("rd2_data", rsp_data, 10'h345);
    drain();

    // Burst lock held by requester 1 for three accesses while 0 and 3 wait
    set_req(1, 1, 0, 19'h100, '0);
    step();
    chk("burst_first", req_ack, 4'b0010);
    n1 = 1;
    set_req(1, 1, 0, 19'h101, '0);
    set_req(0, 0, 0, 19'h200, '0);
    set_req(3, 0, 0, 19'h300, '0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("burst_seq", req_ack, exp33[k]);
      if (m_ack[1]) begin
        n1++;
        if (n1 == 2) set_req(1, 0, 0, 19'h102, '0);
        else req_val[1] = 1'b0;
      end
      if (m_ack[0]) req_val[0] = 1'b0;
      if (m_ack[3]) req_val[3] = 1'b0;
    end
    drain();

    // Write from requester 3
    set_req(3, 0, 1, 19'd5, 10'd150);
    n = 0;
    step();
    while (!req_ack[3] && n < 10) begin step(); n++; end
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 5);
    chk("wr_wdata", mem_wdata, 150);
    chk("wr_which", which_mem, 3);
    req_val[3] = 1'b0;
    step();
    chk("wr_we_drop", mem_we, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wr_no_rsp", rsp_val, 0);
    end

    // Reset one cycle after a read ack discards the in-flight read
    set_req(0, 0, 0, 19'h2AA, '0);
    n = 0;
    step();
    while (!req_ack[0] && n < 10) begin step(); n++; end
    chk("rst_rd_ack", req_ack[0], 1);
    req_val[0] = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rstmid_ack", req_ack, 0);
    chk("rstmid_rsp_val", rsp_val, 0);
    chk("rstmid_rsp_data", rsp_data, 0);
    chk("rstmid_we", mem_we, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_wdata", mem_wdata, 0);
    chk("rstmid_which", which_mem, 0);
    chk("rstmid_count", debug_count, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rstmid_no_rsp", rsp_val, 0);
    end

    // 256 acknowledged cycles wrap debug_count back to zero
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 0, ADDR_W'(i), '0);
    nacks = 0;
    n = 0;
    while (nacks < 256 && n < 800) begin
      step();
      n++;
      if (m_ack != 0) nacks++;
      for (int i = 0; i < NUM_REQ; i++)
        if (m_ack[i]) set_req(i, 0, 0, ADDR_W'($urandom), '0);
    end
    chk("wrap_acks", nacks, 256);
    clear_reqs();
    step();
    chk("wrap_count", debug_count, 0);
    drain();

    // Randomized traffic with occasional reset pulses
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(399, 0) != 0);
      step();
      rand_agents();
    end
    reset = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
